// File: rtl/ce_pacer_pkg.sv
// ce_pacer_pkg: shared types and default widths for the ce_pacer block.
//   state_e      - pacer run state (StIdle, StRun)
//   DivWDefault  - default width of the divide value
//   CntWDefault  - default width of burst length / pulse count
package ce_pacer_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned DivWDefault = 16;
  localparam int unsigned CntWDefault = 8;

endpackage

// File: rtl/ce_pacer_cnt.sv
// ce_pacer_cnt: loadable down-counter with zero flag. Stops at zero.
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset (count -> 0)
//   load_i     - load load_val_i (takes priority over decrement)
//   load_val_i - value to load
//   dec_i      - decrement while non-zero
//   zero_o     - count is zero
module ce_pacer_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ce_pacer.sv
// ce_pacer: programmable clock-enable pacer. Emits one CE strobe every N+1 cycles while
// running, for burst_len strobes (0 = free-run), with a double-buffered divide value.
//   C          - clock, rising edge
//   R          - synchronous active-high reset
//   cfg_div    - requested divide N (period N+1)
//   cfg_valid  - divide-load request; cfg_ready - divide-load accept
//   start      - run request; burst_len - pulses per run (0 = free-run)
//   stop       - abort request (no done)
//   CE         - clock-enable strobe; busy - running; done - burst complete pulse
//   pulse_cnt  - CE strobes issued in the current run
// Build option: define CE_PACER_AUTORELOAD_EN to keep running after each burst
// (done pulses, pulse_cnt restarts at 0); only stop or R then leave RUN.
module ce_pacer
  import ce_pacer_pkg::*;
#(
  parameter int unsigned     DIV_W     = DivWDefault,
  parameter int unsigned     CNT_W     = CntWDefault,
  parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             stop,
  output logic             CE,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             done_q, done_d;

  logic             run, go, ce, last, leave, cfg_xfer, cnt_zero;
  logic [CNT_W-1:0] pcnt_inc;
  logic [DIV_W-1:0] reload_div;

  assign run        = (state_q == StRun);
  assign go         = !run && start && !stop;
  assign ce         = run && cnt_zero && !stop;
  assign pcnt_inc   = pcnt_q + 1'b1;
  assign last       = ce && (len_q != '0) && (pcnt_inc == len_q);
  assign cfg_xfer   = cfg_valid && !pend_q;
  // A pending shadow takes effect at the reload that coincides with the next CE.
  assign reload_div = pend_q ? shadow_q : div_q;

`ifdef CE_PACER_AUTORELOAD_EN
  assign leave = run && stop;
`else
  assign leave = run && (stop || last);
`endif

  // Entering RUN loads 0 so the first CE lands on the first RUN cycle.
  ce_pacer_cnt #(
    .Width (DIV_W)
  ) u_cnt (
    .clk_i      (C),
    .rst_i      (R),
    .load_i     (go || ce),
    .load_val_i (go ? '0 : reload_div),
    .dec_i      (run),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    len_d    = len_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_xfer) begin
          div_d = cfg_div;
        end
        if (go) begin
          state_d = StRun;
          len_d   = burst_len;
          pcnt_d  = '0;
        end
      end
      StRun: begin
        if (ce) begin
          pcnt_d = pcnt_inc;
        end
        if (last) begin
          done_d = 1'b1;
`ifdef CE_PACER_AUTORELOAD_EN
          pcnt_d = '0;
`endif
        end
        if (leave) begin
          state_d = StIdle;
          // Any buffered divide becomes active on the way back to IDLE.
          div_d   = cfg_xfer ? cfg_div : reload_div;
          pend_d  = 1'b0;
        end else if (cfg_xfer) begin
          shadow_d = cfg_div;
          pend_d   = 1'b1;
        end else if (ce && pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q  <= StIdle;
      div_q    <= DIV_RESET;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      len_q    <= '0;
      pcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      len_q    <= len_d;
      pcnt_q   <= pcnt_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready = !pend_q;
  assign CE        = ce;
  assign busy      = run;
  assign done      = done_q;
  assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_ce_pacer.sv
// Scoreboard bench for ce_pacer: stimulus pushes expected CE/done events (cycle, kind,
// pulse_cnt); a negedge monitor pops one per observed strobe and compares.
module tb_ce_pacer;

  localparam int unsigned DivW = 16;
  localparam int unsigned CntW = 8;

  logic            C, R;
  logic [DivW-1:0] cfg_div;
  logic            cfg_valid, cfg_ready;
  logic            start, stop;
  logic [CntW-1:0] burst_len;
  logic            CE, busy, done;
  logic [CntW-1:0] pulse_cnt;

  typedef struct {
    int        cyc;
    bit        is_done;
    bit [7:0]  pcnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;

  ce_pacer #(
    .DIV_W     (DivW),
    .CNT_W     (CntW),
    .DIV_RESET (16'd0)
  ) dut (
    .C         (C),
    .R         (R),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .start     (start),
    .burst_len (burst_len),
    .stop      (stop),
    .CE        (CE),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  initial cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input bit is_done, input int p);
    exp_t e;
    e.cyc     = c;
    e.is_done = is_done;
    e.pcnt    = 8'(p);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input bit is_done);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected %s at cycle %0d: got pulse_cnt %0d, required no event",
               is_done ? "done" : "CE", cyc, pulse_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.cyc != cyc || e.pcnt != pulse_cnt) begin
        n_bad++;
        $display("FAIL event: got %s cyc %0d pulse_cnt %0d, required %s cyc %0d pulse_cnt %0d",
                 is_done ? "done" : "CE", cyc, pulse_cnt,
                 e.is_done ? "done" : "CE", e.cyc, e.pcnt);
      end
    end
  endtask

  // Monitor: done is checked before CE so same-cycle events pop in push order.
  always @(negedge C) begin
    if (done === 1'b1) pop_check(1'b1);
    if (CE === 1'b1) pop_check(1'b0);
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_div(input int n);
    cfg_div   = 16'(n);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  int t;

  initial begin
    R = 1'b1; cfg_div = '0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; burst_len = '0;

    // Reset state
    tick(); tick();
    R = 1'b0;
    tick();
    chk("reset CE", int'(CE), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset pulse_cnt", int'(pulse_cnt), 0);
    chk("reset cfg_ready", int'(cfg_ready), 1);

    // start together with stop in IDLE stays IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start+stop idle busy", int'(busy), 0);

    // N=3, burst of 4
    chk("idle cfg_ready", int'(cfg_ready), 1);
    load_div(3);
    t = cyc;
    start = 1'b1; burst_len = 8'd4;
    push(t + 1, 0, 0); push(t + 5, 0, 1); push(t + 9, 0, 2); push(t + 13, 0, 3);
`ifdef CE_PACER_AUTORELOAD_EN
    push(t + 14, 1, 0);
`else
    push(t + 14, 1, 4);
`endif
    tick();
    start = 1'b0; burst_len = '0;
    chk("burst busy", int'(busy), 1);
    wait_until(t + 14);
    chk("burst done pulse", int'(done), 1);
`ifdef CE_PACER_AUTORELOAD_EN
    chk("autoreload busy at done", int'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("burst pulse_cnt held", int'(pulse_cnt), 0);
`else
    chk("burst end busy", int'(busy), 0);
    tick();
    chk("burst pulse_cnt held", int'(pulse_cnt), 4);
`endif
    chk("burst idle busy", int'(busy), 0);
    chk("burst done single", int'(done), 0);
    chk("burst queue drained", exp_q.size(), 0);

    // N=0 free-run: CE every cycle, pulse_cnt wraps, then stop
    load_div(0);
    t = cyc;
    start = 1'b1; burst_len = '0;
    for (int i = 0; i < 260; i++) push(t + 1 + i, 0, i);
    tick();
    start = 1'b0;
    wait_until(t + 261);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("freerun stop busy", int'(busy), 0);
    chk("freerun stop done", int'(done), 0);
    chk("freerun pulse_cnt", int'(pulse_cnt), 4);
    chk("freerun queue drained", exp_q.size(), 0);

    // N=5 running, reload N=1 mid-period; start in RUN ignored
    load_div(5);
    t = cyc;
    start = 1'b1; burst_len = '0;
    push(t + 1, 0, 0); push(t + 7, 0, 1); push(t + 13, 0, 2);
    push(t + 15, 0, 3); push(t + 17, 0, 4);
    tick();
    start = 1'b0;
    wait_until(t + 5);
    start = 1'b1; burst_len = 8'd1;
    tick();
    start = 1'b0; burst_len = '0;
    wait_until(t + 9);
    chk("shadow cfg_ready before", int'(cfg_ready), 1);
    cfg_div = 16'd1; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("shadow cfg_ready pending", int'(cfg_ready), 0);
    wait_until(t + 13);
    chk("shadow cfg_ready at swap", int'(cfg_ready), 0);
    tick();
    chk("shadow cfg_ready after", int'(cfg_ready), 1);
    wait_until(t + 18);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("shadow stop busy", int'(busy), 0);
    chk("shadow pulse_cnt", int'(pulse_cnt), 5);
    chk("shadow queue drained", exp_q.size(), 0);

    // R mid-burst: N=2, burst 10, reset after 3 CEs
    load_div(2);
    t = cyc;
    start = 1'b1; burst_len = 8'd10;
    push(t + 1, 0, 0); push(t + 4, 0, 1); push(t + 7, 0, 2);
    tick();
    start = 1'b0; burst_len = '0;
    wait_until(t + 8);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort pulse_cnt", int'(pulse_cnt), 0);
    chk("abort cfg_ready", int'(cfg_ready), 1);
    // Active divide is back to 0: a burst of 3 strobes on consecutive cycles
    start = 1'b1; burst_len = 8'd3;
    push(t + 10, 0, 0); push(t + 11, 0, 1); push(t + 12, 0, 2);
`ifdef CE_PACER_AUTORELOAD_EN
    push(t + 13, 1, 0);
`else
    push(t + 13, 1, 3);
`endif
    tick();
    start = 1'b0; burst_len = '0;
    wait_until(t + 13);
`ifdef CE_PACER_AUTORELOAD_EN
    stop = 1'b1;
`endif
    tick();
    stop = 1'b0;
    chk("post-reset burst busy", int'(busy), 0);
    chk("post-reset queue drained", exp_q.size(), 0);

`ifdef CE_PACER_AUTORELOAD_EN
    // Auto-reload: N=1, burst 2 -> done every 4 cycles, busy held until stop
    load_div(1);
    t = cyc;
    start = 1'b1; burst_len = 8'd2;
    push(t + 1, 0, 0); push(t + 3, 0, 1); push(t + 4, 1, 0);
    push(t + 5, 0, 0); push(t + 7, 0, 1); push(t + 8, 1, 0);
    push(t + 9, 0, 0);
    tick();
    start = 1'b0; burst_len = '0;
    wait_until(t + 4);
    chk("autoreload busy 1", int'(busy), 1);
    wait_until(t + 8);
    chk("autoreload busy 2", int'(busy), 1);
    wait_until(t + 10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("autoreload stop busy", int'(busy), 0);
    chk("autoreload queue drained", exp_q.size(), 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
